// File: rtl/sa_pkg.sv
// Shared systolic-array types: element/vector widths and the drain FSM encoding.
package sa_pkg;
  localparam int DATA_W    = 16;
  localparam int ARRAY_DIM = 32;

  typedef logic [DATA_W-1:0] elem_t;
  typedef elem_t [0:ARRAY_DIM-1] vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } drain_state_t;
endpackage

// File: rtl/fifo_drain.sv
// Receive-side lane drain: drops the leading skew beats, assembles ARRAY_DIM
// results into a parallel vector and hands it off through a double-buffered output register.
module fifo_drain #(
  parameter int DATA_W     = sa_pkg::DATA_W,
  parameter int ARRAY_DIM  = sa_pkg::ARRAY_DIM,
  parameter int ZERO_DELAY = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [DATA_W-1:0]                   in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [0:ARRAY_DIM-1][DATA_W-1:0]    out_data,
  output logic                                complete_flag,
  output logic                                drop_flag,
  output logic [1:0]                          dbg_state
);
  import sa_pkg::*;

  // Handshakes: a beat moves when in_valid & in_ready, a vector moves when
  // out_valid & out_ready; valid never waits on ready and holds until taken.

  localparam int SKIP_W = $clog2(ARRAY_DIM + 1);
  localparam int PTR_W  = $clog2(ARRAY_DIM);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((ZERO_DELAY > 0) ? ZERO_DELAY - 1 : 0);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(ARRAY_DIM - 1);

  drain_state_t state, state_nxt;
  logic [SKIP_W-1:0]                 skip_cnt;
  logic [PTR_W-1:0]                  wr_ptr;
  logic [0:ARRAY_DIM-1][DATA_W-1:0]  col_buf;
  logic [0:ARRAY_DIM-1][DATA_W-1:0]  load_vec;
  logic accept, last_beat, out_take, out_free, load_out;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (ZERO_DELAY > 0) ? SKIP : COLLECT;
      SKIP:    if (accept && skip_cnt == SKIP_LAST) state_nxt = COLLECT;
      COLLECT: if (last_beat) state_nxt = out_free ? IDLE : HOLD;
      HOLD:    if (out_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == SKIP) || (state == COLLECT);
    accept    = in_valid && in_ready;
    out_take  = out_valid && out_ready;
    out_free  = !out_valid || out_take;
    last_beat = (state == COLLECT) && accept && (wr_ptr == PTR_LAST);
    // The terminal beat bypasses the buffer so the vector is ready one cycle later.
    load_vec  = col_buf;
    if (last_beat) load_vec[ARRAY_DIM-1] = in_data;
    load_out  = (last_beat && out_free) || ((state == HOLD) && out_take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt  <= '0;
      wr_ptr    <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        skip_cnt <= '0;
        wr_ptr   <= '0;
      end
      if (state == SKIP && accept) skip_cnt <= skip_cnt + 1'b1;
      if (state == COLLECT && accept && !last_beat) wr_ptr <= wr_ptr + 1'b1;
      if (in_valid && !in_ready) drop_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == COLLECT && accept) col_buf[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      complete_flag <= 1'b0;
    end else begin
      complete_flag <= load_out;
      if (load_out) begin
        out_data  <= load_vec;
        out_valid <= 1'b1;
      end else if (out_take) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: two lanes (skew 0 and skew 5) checked every cycle against
// a beat-counting reference model plus directed literal checks.
module tb_fifo_drain;
  localparam int W   = 16;
  localparam int N   = 32;
  localparam int ZD0 = 0;
  localparam int ZD1 = 5;

  typedef logic [0:N-1][W-1:0] vec_l;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], start[2], in_valid[2], out_ready[2];
  logic [W-1:0] in_data[2];
  logic       in_ready[2], out_valid[2], complete_flag[2], drop_flag[2];
  logic [1:0] dbg_state[2];
  vec_l       out_data[2];

  fifo_drain #(.DATA_W(W), .ARRAY_DIM(N), .ZERO_DELAY(ZD0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .complete_flag(complete_flag[0]), .drop_flag(drop_flag[0]),
    .dbg_state(dbg_state[0])
  );

  fifo_drain #(.DATA_W(W), .ARRAY_DIM(N), .ZERO_DELAY(ZD1)) u_dut5 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .complete_flag(complete_flag[1]), .drop_flag(drop_flag[1]),
    .dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input vec_l act, input vec_l exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Counts accepted beats since arming; beats past the skew fill the vector.
  bit   m_armed[2] = '{0, 0};
  bit   m_pend[2]  = '{0, 0};
  bit   m_ov[2]    = '{0, 0};
  bit   m_cf[2]    = '{0, 0};
  bit   m_drop[2]  = '{0, 0};
  int   m_beats[2] = '{0, 0};
  vec_l m_col[2];
  vec_l m_out[2];

  function automatic int zd(input int d);
    return (d == 0) ? ZD0 : ZD1;
  endfunction

  function automatic bit m_ready(input int d);
    return m_armed[d] && !m_pend[d];
  endfunction

  task automatic model_step(input int d);
    bit rdy, acc, take, idle;
    int k;
    if (rst[d]) begin
      m_armed[d] = 0; m_pend[d] = 0; m_ov[d] = 0; m_cf[d] = 0; m_drop[d] = 0;
      m_beats[d] = 0; m_out[d] = '0;
      return;
    end
    rdy  = m_ready(d);
    acc  = in_valid[d] && rdy;
    take = m_ov[d] && out_ready[d];
    idle = !m_armed[d] && !m_pend[d];
    if (in_valid[d] && !rdy) m_drop[d] = 1;
    m_cf[d] = 0;
    if (take) m_ov[d] = 0;
    if (m_pend[d] && take) begin
      m_out[d] = m_col[d]; m_ov[d] = 1; m_cf[d] = 1; m_pend[d] = 0;
    end else if (acc) begin
      if (m_beats[d] >= zd(d)) begin
        k = m_beats[d] - zd(d);
        m_col[d][k] = in_data[d];
        if (k == N - 1) begin
          m_armed[d] = 0;
          if (!m_ov[d]) begin
            m_out[d] = m_col[d]; m_ov[d] = 1; m_cf[d] = 1;
          end else begin
            m_pend[d] = 1;
          end
        end
      end
      m_beats[d]++;
    end else if (start[d] && idle) begin
      m_armed[d] = 1;
      m_beats[d] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // Per-cycle compare, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cyc_in_ready[%0d]", d), 64'(in_ready[d]), 64'(m_ready(d)));
        check($sformatf("cyc_out_valid[%0d]", d), 64'(out_valid[d]), 64'(m_ov[d]));
        check($sformatf("cyc_complete[%0d]", d), 64'(complete_flag[d]), 64'(m_cf[d]));
        check($sformatf("cyc_drop[%0d]", d), 64'(drop_flag[d]), 64'(m_drop[d]));
        if (m_ov[d]) check_vec($sformatf("cyc_out_data[%0d]", d), out_data[d], m_out[d]);
      end
    end
  end

  // ---------------- driver tasks (entered right after a negedge) ----------------
  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic send_run(input int d, input int base, input int step, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = W'(base + i * step);
      @(negedge clk);
      if (gap && i < n - 1) begin
        in_valid[d] = 1'b0;
        @(negedge clk);
      end
    end
    in_valid[d] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", 64'(out_valid[d]), 64'd0);
      check("rst_in_ready", 64'(in_ready[d]), 64'd0);
      check("rst_drop", 64'(drop_flag[d]), 64'd0);
      check("rst_complete", 64'(complete_flag[d]), 64'd0);
      check("rst_state", 64'(dbg_state[d]), 64'(sa_pkg::IDLE));
      check_vec("rst_out_data", out_data[d], '0);
      rst[d] = 1'b0;
    end
    chk_en = 1'b1;

    // Skew 0, gapless, sink always ready.
    out_ready[0] = 1'b1;
    pulse_start(0);
    send_run(0, 'h0001, 1, N, 1'b0);
    check("t1_valid", 64'(out_valid[0]), 64'd1);
    check("t1_elem0", 64'(out_data[0][0]), 64'h0001);
    check("t1_elem31", 64'(out_data[0][31]), 64'h0020);
    check("t1_complete", 64'(complete_flag[0]), 64'd1);
    check("t1_state", 64'(dbg_state[0]), 64'(sa_pkg::IDLE));
    @(negedge clk);
    check("t1_complete_pulse", 64'(complete_flag[0]), 64'd0);
    check("t1_valid_drop", 64'(out_valid[0]), 64'd0);

    // Skew 5: leading padding discarded.
    out_ready[1] = 1'b1;
    pulse_start(1);
    send_run(1, 'hDEAD, 0, ZD1, 1'b0);
    send_run(1, 'h0100, 1, N, 1'b0);
    check("t2_valid", 64'(out_valid[1]), 64'd1);
    check("t2_elem0", 64'(out_data[1][0]), 64'h0100);
    check("t2_elem31", 64'(out_data[1][31]), 64'h011F);
    found = 1'b0;
    for (int k = 0; k < N; k++) if (out_data[1][k] == 16'hDEAD) found = 1'b1;
    check("t2_no_pad", 64'(found), 64'd0);

    // Backpressure: A parked, B fills and waits in HOLD.
    out_ready[0] = 1'b0;
    pulse_start(0);
    send_run(0, 'h0200, 1, N, 1'b0);
    check("t3_a_valid", 64'(out_valid[0]), 64'd1);
    pulse_start(0);
    send_run(0, 'h0300, 1, N, 1'b0);
    check("t3_hold_state", 64'(dbg_state[0]), 64'(sa_pkg::HOLD));
    check("t3_hold_ready", 64'(in_ready[0]), 64'd0);
    repeat (2) @(negedge clk);
    check("t3_a_stable0", 64'(out_data[0][0]), 64'h0200);
    check("t3_a_stable31", 64'(out_data[0][31]), 64'h021F);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("t3_b_elem0", 64'(out_data[0][0]), 64'h0300);
    check("t3_b_elem31", 64'(out_data[0][31]), 64'h031F);
    check("t3_b_valid", 64'(out_valid[0]), 64'd1);
    check("t3_b_complete", 64'(complete_flag[0]), 64'd1);
    check("t3_idle", 64'(dbg_state[0]), 64'(sa_pkg::IDLE));
    @(negedge clk);
    check("t3_b_held", 64'(out_valid[0]), 64'd1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("t3_b_taken", 64'(out_valid[0]), 64'd0);

    // Gapped input: same vector, latency counted from the last valid beat.
    pulse_start(0);
    send_run(0, 'h0400, 1, N, 1'b1);
    check("t4_valid", 64'(out_valid[0]), 64'd1);
    check("t4_complete", 64'(complete_flag[0]), 64'd1);
    check("t4_elem0", 64'(out_data[0][0]), 64'h0400);
    check("t4_elem31", 64'(out_data[0][31]), 64'h041F);

    // Illegal traffic: beat while idle, then start mid-collection.
    in_valid[1] = 1'b1; in_data[1] = 16'h5555;
    @(negedge clk);
    in_valid[1] = 1'b0;
    check("t5_drop", 64'(drop_flag[1]), 64'd1);
    check("t5_no_capture", 64'(out_valid[1]), 64'd0);
    pulse_start(1);
    send_run(1, 'hDEAD, 0, ZD1, 1'b0);
    send_run(1, 'h0500, 1, 10, 1'b0);
    pulse_start(1);
    send_run(1, 'h050A, 1, N - 10, 1'b0);
    check("t5_valid", 64'(out_valid[1]), 64'd1);
    check("t5_elem0", 64'(out_data[1][0]), 64'h0500);
    check("t5_elem10", 64'(out_data[1][10]), 64'h050A);
    check("t5_elem31", 64'(out_data[1][31]), 64'h051F);
    check("t5_drop_sticky", 64'(drop_flag[1]), 64'd1);

    // Reset mid-collection, then a clean vector.
    pulse_start(0);
    send_run(0, 'h0600, 1, 10, 1'b0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("t6_valid", 64'(out_valid[0]), 64'd0);
    check("t6_ready", 64'(in_ready[0]), 64'd0);
    check("t6_complete", 64'(complete_flag[0]), 64'd0);
    check("t6_drop", 64'(drop_flag[0]), 64'd0);
    check("t6_state", 64'(dbg_state[0]), 64'(sa_pkg::IDLE));
    check_vec("t6_data_clr", out_data[0], '0);
    pulse_start(0);
    send_run(0, 'h0700, 1, N, 1'b0);
    check("t6_new_valid", 64'(out_valid[0]), 64'd1);
    for (int k = 0; k < N; k++)
      check($sformatf("t6_elem%0d", k), 64'(out_data[0][k]), 64'('h0700 + k));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Receive-side counterpart of the staggered injection buffers. One instance sits on each row/column output edge of the systolic array.
- Consumes the skewed serial result stream for that lane and discards the leading skew cycles (zero padding).
- Assembles ARRAY_DIM results into one parallel vector and hands it downstream on a valid/ready handshake.
- Double-buffered: a completed vector waits in an output register while the next arming can begin.

Parameters:
- DATA_W, 16, element width in bits.
- ARRAY_DIM, 32, elements per assembled vector.
- ZERO_DELAY, 0, leading in_valid beats discarded before collection starts (lane skew); legal range 0..ARRAY_DIM.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- start  input  1  arm pulse; honoured only in IDLE.
- in_valid  input  1  serial beat from array present.
- in_data  input  DATA_W  serial result element.
- in_ready  output  1  block accepts a beat this cycle.
- out_valid  output  1  out_data holds a complete vector.
- out_ready  input  1  downstream consumes the vector.
- out_data  output  DATA_W x [0:ARRAY_DIM-1]  assembled vector; element 0 = first collected beat.
- complete_flag  output  1  one-cycle pulse when a vector is loaded into the output register.
- drop_flag  output  1  sticky; set when in_valid=1 while in_ready=0.

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, even mid-operation; any partial vector is lost:
  - state=IDLE, skip_cnt=0, wr_ptr=0.
  - out_valid=0, complete_flag=0, drop_flag=0, in_ready=0.
  - out_data is cleared to 0.
- A beat is accepted on a cycle with in_valid & in_ready.
- State machine states: IDLE, SKIP, COLLECT, HOLD.
- IDLE:
  - in_ready=0.
  - On start: go to SKIP if ZERO_DELAY>0, otherwise to COLLECT. skip_cnt and wr_ptr are cleared.
- SKIP:
  - in_ready=1.
  - Each accepted beat is discarded and increments skip_cnt.
  - The beat accepted while skip_cnt==ZERO_DELAY-1 moves to COLLECT. No data is written on that beat.
- COLLECT:
  - in_ready=1.
  - Each accepted beat writes buf[wr_ptr] and increments wr_ptr.
  - On the beat with wr_ptr==ARRAY_DIM-1 (the final element):
    - If the output register is free (out_valid=0, or out_valid&out_ready this cycle): the next cycle out_data = full vector including this beat, out_valid=1, complete_flag=1, state=IDLE.
    - Otherwise: go to HOLD.
- HOLD:
  - in_ready=0.
  - When out_valid&out_ready: the buffer transfers on the following edge, out_valid stays 1, complete_flag pulses, state=IDLE.
- Latency: out_valid rises exactly one cycle after the final beat is accepted, when the output register is free.
- Output handshake:
  - out_valid, once set, holds until out_valid&out_ready.
  - out_data is stable while out_valid=1 && out_ready=0.
  - If the vector is consumed with no new transfer that cycle, out_valid drops the next cycle.
- start outside IDLE is ignored. start in IDLE in the same cycle as an in_valid does not accept that beat (in_ready=0).
- drop_flag sets on any in_valid while in_ready=0 (IDLE, HOLD). It clears only on reset.
- Counters:
  - skip_cnt width is $clog2(ARRAY_DIM+1).
  - wr_ptr width is $clog2(ARRAY_DIM).
  - wr_ptr never wraps: the terminal beat ends collection.

Decomposition:
- Shared package sa_pkg holds:
  - DATA_W=16 and ARRAY_DIM=32 constants.
  - typedef elem_t (logic [DATA_W-1:0]).
  - typedef vec_t (elem_t [0:ARRAY_DIM-1]).
  - enum drain_state_t {IDLE, SKIP, COLLECT, HOLD}.
- No sub-module. Collection buffer, counters and output register live in one module, with a separate output-register always_ff block.

Test Plan:
- ZERO_DELAY=0: start, then 32 consecutive beats 0x0001..0x0020 with out_ready=1 -> out_valid the cycle after beat 32, out_data[0]=0x0001, out_data[31]=0x0020, complete_flag one pulse, state back to IDLE.
- ZERO_DELAY=5: start, then 37 beats where the first 5 are 0xDEAD and the rest are 0x0100+i -> out_data[0]=0x0100, out_data[31]=0x011F, no 0xDEAD anywhere in the vector.
- Backpressure: hold out_ready=0 after vector A, run a second start plus 32 beats (B) -> FSM enters HOLD with in_ready=0 and out_data=A stable. Raise out_ready for one cycle -> out_data=B next cycle, out_valid stays 1, complete_flag pulses.
- Gapped input: in_valid toggling 1/0 across the 32 beats -> vector identical to the gapless case, with out_valid one cycle after the last valid beat.
- Illegal traffic: in_valid=1 in IDLE without start -> drop_flag=1 and no data captured; start in COLLECT -> ignored, wr_ptr unchanged.
- Reset mid-COLLECT after 10 beats (rst=1 for 1 cycle) -> all outputs 0, state IDLE. A fresh start plus 32 beats then yields a correct vector containing none of the earlier data.
